// File: rtl/usb_hid_pkg.sv
// usb_hid_pkg: shared types and constants for the HID key event generator
package usb_hid_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MOD, S_REL, S_PRS, S_COMMIT} state_t;
  localparam logic [7:0] HID_MOD_BASE      = 8'hE0;
  localparam logic [7:0] HID_ERR_ROLLOVER  = 8'h01;
  localparam logic [7:0] HID_ERR_POSTFAIL  = 8'h02;
  localparam logic [7:0] HID_ERR_UNDEFINED = 8'h03;
  typedef logic [5:0][7:0] key_arr_t;
  typedef struct packed {
    logic [7:0] mod;
    key_arr_t   key;
  } key_report_t;
  function automatic logic is_rollover(input key_report_t r);
    is_rollover = 1'b0;
    for (int i = 0; i < 6; i++)
      if (r.key[i] inside {HID_ERR_ROLLOVER, HID_ERR_POSTFAIL, HID_ERR_UNDEFINED}) is_rollover = 1'b1;
  endfunction
  function automatic logic in_first(input key_arr_t keys, input logic [7:0] k, input logic [2:0] n);
    in_first = 1'b0;
    for (int i = 0; i < 6; i++)
      if (i < int'(n) && keys[i] == k) in_first = 1'b1;
  endfunction
endpackage

// File: rtl/usb_hid_key_event_gen_fifo.sv
// usb_event_fifo: first-word-fall-through event FIFO of {press, code} entries
module usb_event_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign empty  = r_cnt == '0;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];
  // Pointer and occupancy bookkeeping; a pop frees room for a same-cycle push when full
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= din;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/usb_hid_key_event_gen.sv
// usb_hid_key_event_gen: turns level-style boot keyboard reports into press/release events
import usb_hid_pkg::*;
module usb_hid_key_event_gen #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        report_valid,
  input  logic [7:0]  report_modifiers,
  input  logic [7:0]  report_key0,
  input  logic [7:0]  report_key1,
  input  logic [7:0]  report_key2,
  input  logic [7:0]  report_key3,
  input  logic [7:0]  report_key4,
  input  logic [7:0]  report_key5,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_code,
  output logic        evt_press,
  output logic        busy,
  output logic [15:0] dropped_count,
  output logic [15:0] rollover_count
);
  state_t      r_state, w_state_nxt;
  key_report_t r_prev, r_cur, r_pend, w_in, w_src;
  logic        r_pend_v;
  logic [2:0]  r_step, w_step_nxt;
  logic [15:0] r_dropped, r_rollover;
  logic        w_load_req, w_roll, w_to_pend, w_drop, w_full, w_empty, w_pop, w_push_ok;
  logic        w_need, w_adv, w_press, w_rel_need, w_prs_need;
  logic [7:0]  w_code, w_rel_k, w_prs_k;
  logic [8:0]  w_dout;
  assign w_in       = {report_modifiers, report_key5, report_key4, report_key3, report_key2, report_key1, report_key0};
  assign w_src      = r_pend_v ? r_pend : w_in;
  assign w_roll     = is_rollover(w_src);
  assign w_load_req = enable && r_state == S_IDLE && (r_pend_v || report_valid);
  assign w_to_pend  = enable && report_valid && (r_state != S_IDLE || r_pend_v);
  assign w_drop     = w_to_pend && r_pend_v && r_state != S_IDLE;
  assign w_pop      = !w_empty && evt_ready;
  assign w_push_ok  = !w_full || w_pop;
  assign w_adv      = !w_need || w_push_ok;
  // Decide whether the current scan step owes an event, and which one
  always_comb begin
    w_rel_k    = r_prev.key[r_step];
    w_prs_k    = r_cur.key[r_step];
    w_rel_need = w_rel_k != 8'h00 && !in_first(r_cur.key, w_rel_k, 3'd6) && !in_first(r_prev.key, w_rel_k, r_step);
    w_prs_need = w_prs_k != 8'h00 && !in_first(r_prev.key, w_prs_k, 3'd6) && !in_first(r_cur.key, w_prs_k, r_step);
    w_need     = (r_state == S_MOD && r_cur.mod[r_step] != r_prev.mod[r_step]) ||
                 (r_state == S_REL && w_rel_need) || (r_state == S_PRS && w_prs_need);
    w_code     = r_state == S_MOD ? (HID_MOD_BASE | {5'd0, r_step}) : r_state == S_REL ? w_rel_k : w_prs_k;
    w_press    = r_state == S_MOD ? r_cur.mod[r_step] : r_state == S_PRS;
  end
  // Scan sequencing; a step holds while its event cannot enter the FIFO
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: if (w_load_req && !w_roll) begin
        w_state_nxt = S_MOD;
        w_step_nxt  = 3'd0;
      end
      S_MOD: if (w_adv) begin
        w_state_nxt = r_step == 3'd7 ? S_REL : S_MOD;
        w_step_nxt  = r_step + 3'd1;
      end
      S_REL: if (w_adv) begin
        w_state_nxt = r_step == 3'd5 ? S_PRS : S_REL;
        w_step_nxt  = r_step == 3'd5 ? 3'd0 : r_step + 3'd1;
      end
      S_PRS: if (w_adv) begin
        w_state_nxt = r_step == 3'd5 ? S_COMMIT : S_PRS;
        w_step_nxt  = r_step == 3'd5 ? 3'd0 : r_step + 3'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // FSM and report registers; disabling wipes history so the next report is seen fresh
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_prev   <= '0;
      r_cur    <= '0;
      r_pend_v <= 1'b0;
      if (rst) r_pend <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      if (w_load_req && !w_roll) r_cur <= w_src;
      if (r_state == S_COMMIT) r_prev <= r_cur;
      if (w_to_pend) r_pend <= w_in;
      if (w_to_pend) r_pend_v <= 1'b1;
      else if (w_load_req && r_pend_v) r_pend_v <= 1'b0;
    end
  end
  // Saturating diagnostics counters, held across disable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped  <= '0;
      r_rollover <= '0;
    end else begin
      if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      if (w_load_req && w_roll && r_rollover != 16'hFFFF) r_rollover <= r_rollover + 16'd1;
    end
  end
  usb_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enable),
    .push  (w_need && w_push_ok),
    .pop   (evt_ready),
    .din   ({w_press, w_code}),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );
  assign evt_valid      = !w_empty;
  assign evt_code       = w_empty ? 8'h00 : w_dout[7:0];
  assign evt_press      = !w_empty && w_dout[8];
  assign busy           = r_state != S_IDLE;
  assign dropped_count  = r_dropped;
  assign rollover_count = r_rollover;
endmodule

// File: tb/tb_usb_hid_key_event_gen.sv
// tb_usb_hid_key_event_gen: directed scoreboard bench for the HID key event generator
module tb_usb_hid_key_event_gen;
  logic        clk = 1'b0, rst, enable, report_valid, evt_ready, evt_valid, evt_press, busy;
  logic [7:0]  report_modifiers, k0, k1, k2, k3, k4, k5, evt_code;
  logic [15:0] dropped_count, rollover_count;
  logic [8:0]  sb[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0, cyc_n = 0, t0 = 0;
  always #5 clk = ~clk;
  usb_hid_key_event_gen #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .report_valid(report_valid),
    .report_modifiers(report_modifiers), .report_key0(k0), .report_key1(k1), .report_key2(k2),
    .report_key3(k3), .report_key4(k4), .report_key5(k5), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_press(evt_press), .busy(busy), .dropped_count(dropped_count),
    .rollover_count(rollover_count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic ex(input logic p, input logic [7:0] c);
    sb.push_back({p, c});
  endtask
  task automatic cyc();
    logic [8:0] exp;
    if (evt_valid === 1'b1 && evt_ready) begin
      exp = 9'h1FF;
      if (sb.size() > 0) exp = sb.pop_front();
      check("evt", {evt_press, evt_code}, exp);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask
  task automatic set_in(input logic [7:0] m, a, b, c, d, e, f);
    report_modifiers = m;
    {k0, k1, k2, k3, k4, k5} = {a, b, c, d, e, f};
  endtask
  task automatic send(input logic [7:0] m, a, b, c, d, e, f);
    set_in(m, a, b, c, d, e, f);
    report_valid = 1'b1;
    t0 = cyc_n;
    cyc();
    report_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin cyc(); n++; end
    check(tag, busy, 0);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    evt_ready = 1'b1;
    while ((sb.size() > 0 || busy) && n < 300) begin cyc(); n++; end
    check({tag, "_left"}, sb.size(), 0);
    cyc();
    check({tag, "_extra"}, evt_valid, 0);
  endtask
  initial begin
    #2000000;
    $error("FAIL timeout");
    $fatal(1, "bench timeout");
  end
  initial begin
    rst = 1'b1; enable = 1'b1; report_valid = 1'b0; evt_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    check("rst_valid", evt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_code", {evt_press, evt_code}, 0);
    check("rst_drop", dropped_count, 0);
    check("rst_roll", rollover_count, 0);
    // single key: press appears after the PRS step 0 push, scan ends at T+22
    ex(1, 8'h04);
    send(8'h00, 8'h04, 0, 0, 0, 0, 0);
    check("key_busy", busy, 1);
    while (!evt_valid && cyc_n - t0 < 40) cyc();
    check("key_lat", cyc_n - t0, 16);
    wait_idle("key_idle");
    check("key_idle_t", cyc_n - t0, 22);
    drain("key_p");
    ex(0, 8'h04);
    send(8'h00, 0, 0, 0, 0, 0, 0);
    drain("key_r");
    // modifiers
    evt_ready = 1'b0;
    ex(1, 8'hE1); ex(1, 8'hE5);
    send(8'h22, 0, 0, 0, 0, 0, 0);
    cyc();
    check("mod_t2", evt_valid, 0);
    cyc();
    check("mod_t3", {evt_valid, evt_press, evt_code}, {2'b11, 8'hE1});
    drain("mod_a");
    ex(0, 8'hE5);
    send(8'h02, 0, 0, 0, 0, 0, 0);
    drain("mod_b");
    // duplicates and rollover
    ex(1, 8'h05);
    send(8'h02, 8'h05, 8'h05, 0, 0, 0, 0);
    drain("dup");
    send(8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    check("roll_busy", busy, 0);
    check("roll_cnt", rollover_count, 1);
    repeat (3) cyc();
    check("roll_noevt", evt_valid, 0);
    ex(0, 8'hE1); ex(0, 8'h05);
    send(8'h00, 0, 0, 0, 0, 0, 0);
    drain("roll_rel");
    // back-pressure: 28 events through a 16-deep FIFO
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) ex(1, 8'hE0 + 8'(i));
    for (int i = 4; i < 10; i++) ex(1, 8'(i));
    send(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    check("bp_t1", evt_valid, 0);
    cyc();
    check("bp_t2", {evt_valid, evt_press, evt_code}, {2'b11, 8'hE0});
    wait_idle("bp_idle1");
    for (int i = 0; i < 8; i++) ex(0, 8'hE0 + 8'(i));
    for (int i = 4; i < 10; i++) ex(0, 8'(i));
    send(8'h00, 0, 0, 0, 0, 0, 0);
    repeat (40) cyc();
    check("bp_stall_busy", busy, 1);
    check("bp_stall_valid", evt_valid, 1);
    drain("bp");
    // pending overwrite: strobes at T0 (starts scan), T0+2 and T0+4
    ex(1, 8'h04); ex(0, 8'h04); ex(1, 8'h07);
    send(8'h00, 8'h04, 0, 0, 0, 0, 0);
    cyc();
    set_in(8'h00, 8'h06, 0, 0, 0, 0, 0);
    report_valid = 1'b1; cyc(); report_valid = 1'b0;
    cyc();
    set_in(8'h00, 8'h07, 0, 0, 0, 0, 0);
    report_valid = 1'b1; cyc(); report_valid = 1'b0;
    while (cyc_n - t0 < 22) cyc();
    check("pend_idle", busy, 0);
    cyc();
    check("pend_next", busy, 1);
    drain("pend");
    check("pend_drop", dropped_count, 1);
    // flush mid-REL
    evt_ready = 1'b0;
    send(8'h01, 8'h08, 0, 0, 0, 0, 0);
    while (cyc_n - t0 < 11) cyc();
    check("fl_pre", evt_valid, 1);
    enable = 1'b0;
    cyc();
    check("fl_valid", evt_valid, 0);
    check("fl_busy", busy, 0);
    enable = 1'b1;
    cyc();
    ex(1, 8'h04);
    send(8'h00, 8'h04, 0, 0, 0, 0, 0);
    drain("fl_after");
    check("fl_drop_hold", dropped_count, 1);
    check("fl_roll_hold", rollover_count, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
